// File: rtl/pipe_pkg.sv
// Shared types and constants for the Decode-to-Execute pipeline register.
//   COND_AL     : "always" condition code, the neutral value for an empty slot
//   ctrl_e_t    : control bundle carried from Decode into Execute
//   CTRL_BUBBLE : control bundle of an empty (bubble) slot
package pipe_pkg;

  localparam logic [3:0] COND_AL = 4'hE;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic [3:0] cond;
    logic       valid;
  } ctrl_e_t;

  localparam int unsigned CTRL_W = $bits(ctrl_e_t);

  // Everything disabled, condition AL: the slot has no architectural effect.
  localparam ctrl_e_t CTRL_BUBBLE = '{
    pcs:         1'b0,
    regw:        1'b0,
    memw:        1'b0,
    branch:      1'b0,
    memtoreg:    1'b0,
    alusrc:      1'b0,
    alu_control: 2'b00,
    flag_w:      2'b00,
    cond:        COND_AL,
    valid:       1'b0
  };

endpackage

// File: rtl/de_ex_pipe_reg_flopenrc_n.sv
// Parameterised register with enable and synchronous clear.
//   clk, reset : clock, asynchronous active-low reset (loads INIT)
//   en         : load d on the rising edge
//   clr        : load INIT on the rising edge; takes priority over en
//   d, q       : data in / registered data out
module flopenrc_n #(
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= INIT;
    end else if (clr) begin
      q <= INIT;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/de_ex_pipe_reg.sv
// Decode-to-Execute pipeline register with stall, flush, valid tracking and a
// saturating count of inserted bubbles.
//   clk, reset          : clock, asynchronous active-low reset
//   StallE, FlushE      : hazard-unit hold / bubble-insert requests
//   ValidD              : decode slot holds a real instruction
//   *D control/addr/data: decoded fields entering Execute
//   *E outputs          : registered copies presented to Execute
//   ValidE              : Execute slot holds a real instruction
//   BubbleCnt           : bubbles inserted by FlushE since reset (saturating)
module de_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RAW   = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic             PCSD,
  input  logic             RegWD,
  input  logic             MemWD,
  input  logic             BranchD,
  input  logic             MemtoRegD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ALUControlD,
  input  logic [1:0]       FlagWD,
  input  logic [3:0]       CondD,
  input  logic [RAW-1:0]   RA1D,
  input  logic [RAW-1:0]   RA2D,
  input  logic [RAW-1:0]   WA3D,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ExtImmD,
  output logic             PCSE,
  output logic             RegWE,
  output logic             MemWE,
  output logic             BranchE,
  output logic             MemtoRegE,
  output logic             ALUSrcE,
  output logic [1:0]       ALUControlE,
  output logic [1:0]       FlagWE,
  output logic [3:0]       CondE,
  output logic [RAW-1:0]   RA1E,
  output logic [RAW-1:0]   RA2E,
  output logic [RAW-1:0]   WA3E,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic             ValidE,
  output logic [CNTW-1:0]  BubbleCnt
);

  localparam int unsigned   ADDR_W  = 3 * RAW;
  localparam int unsigned   DATA_W  = 3 * WIDTH;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  ctrl_e_t           ctrl_d;
  ctrl_e_t           ctrl_e;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_e;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_e;
  logic              load_en;
  logic              load_clr;

  // Flush beats stall; an invalid decode slot also loads bubble contents.
  assign load_en  = !StallE;
  assign load_clr = FlushE || (!StallE && !ValidD);

  // Decode-side bundle assembly.
  always_comb begin
    ctrl_d             = CTRL_BUBBLE;
    ctrl_d.pcs         = PCSD;
    ctrl_d.regw        = RegWD;
    ctrl_d.memw        = MemWD;
    ctrl_d.branch      = BranchD;
    ctrl_d.memtoreg    = MemtoRegD;
    ctrl_d.alusrc      = ALUSrcD;
    ctrl_d.alu_control = ALUControlD;
    ctrl_d.flag_w      = FlagWD;
    ctrl_d.cond        = CondD;
    ctrl_d.valid       = ValidD;
  end

  assign addr_d = {RA1D, RA2D, WA3D};
  assign data_d = {RD1D, RD2D, ExtImmD};

  flopenrc_n #(
    .W    (CTRL_W),
    .INIT (CTRL_BUBBLE)
  ) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (load_clr),
    .d     (ctrl_d),
    .q     (ctrl_e)
  );

  flopenrc_n #(
    .W    (ADDR_W),
    .INIT ('0)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (load_clr),
    .d     (addr_d),
    .q     (addr_e)
  );

  flopenrc_n #(
    .W    (DATA_W),
    .INIT ('0)
  ) u_data (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .clr   (load_clr),
    .d     (data_d),
    .q     (data_e)
  );

  // Bubble counter: counts flush edges only, sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BubbleCnt <= '0;
    end else if (FlushE && (BubbleCnt != CNT_MAX)) begin
      BubbleCnt <= BubbleCnt + CNTW'(1);
    end
  end

  assign PCSE        = ctrl_e.pcs;
  assign RegWE       = ctrl_e.regw;
  assign MemWE       = ctrl_e.memw;
  assign BranchE     = ctrl_e.branch;
  assign MemtoRegE   = ctrl_e.memtoreg;
  assign ALUSrcE     = ctrl_e.alusrc;
  assign ALUControlE = ctrl_e.alu_control;
  assign FlagWE      = ctrl_e.flag_w;
  assign CondE       = ctrl_e.cond;
  assign ValidE      = ctrl_e.valid;

  assign RA1E    = addr_e[ADDR_W-1     -: RAW];
  assign RA2E    = addr_e[2*RAW-1      -: RAW];
  assign WA3E    = addr_e[RAW-1        -: RAW];
  assign RD1E    = data_e[DATA_W-1     -: WIDTH];
  assign RD2E    = data_e[2*WIDTH-1    -: WIDTH];
  assign ExtImmE = data_e[WIDTH-1      -: WIDTH];

endmodule

// File: tb/tb_de_ex_pipe_reg.sv
// Self-checking bench for de_ex_pipe_reg (CNTW=4 so saturation is reachable).
module tb_de_ex_pipe_reg;

  typedef struct packed {
    logic [5:0]  ctl;   // {PCS, RegW, MemW, Branch, MemtoReg, ALUSrc}
    logic [1:0]  aluc;
    logic [1:0]  flagw;
    logic [3:0]  cond;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic        valid;
  } side_t;

  typedef struct packed {
    logic       flush;
    logic       stall;
    side_t      d;
    side_t      e;
    logic [3:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic StallE, FlushE, ValidD;
  logic PCSD, RegWD, MemWD, BranchD, MemtoRegD, ALUSrcD;
  logic [1:0] ALUControlD, FlagWD;
  logic [3:0] CondD, RA1D, RA2D, WA3D;
  logic [31:0] RD1D, RD2D, ExtImmD;
  logic PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE;
  logic [1:0] ALUControlE, FlagWE;
  logic [3:0] CondE, RA1E, RA2E, WA3E;
  logic [31:0] RD1E, RD2E, ExtImmE;
  logic ValidE;
  logic [3:0] BubbleCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  de_ex_pipe_reg #(.WIDTH(32), .RAW(4), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD), .BranchD(BranchD),
    .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .FlagWD(FlagWD), .CondD(CondD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
    .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE), .BranchE(BranchE),
    .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .FlagWE(FlagWE), .CondE(CondE), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .ValidE(ValidE),
    .BubbleCnt(BubbleCnt)
  );

  function automatic side_t mk(logic [5:0] ctl, logic [1:0] aluc, logic [1:0] flagw,
                               logic [3:0] cond, logic [3:0] ra1, logic [3:0] ra2,
                               logic [3:0] wa3, logic [31:0] rd1, logic [31:0] rd2,
                               logic [31:0] ext, logic valid);
    side_t s;
    s.ctl = ctl; s.aluc = aluc; s.flagw = flagw; s.cond = cond;
    s.ra1 = ra1; s.ra2 = ra2; s.wa3 = wa3;
    s.rd1 = rd1; s.rd2 = rd2; s.ext = ext; s.valid = valid;
    return s;
  endfunction

  task automatic drive(input logic flush, input logic stall, input side_t s);
    FlushE = flush; StallE = stall; ValidD = s.valid;
    {PCSD, RegWD, MemWD, BranchD, MemtoRegD, ALUSrcD} = s.ctl;
    ALUControlD = s.aluc; FlagWD = s.flagw; CondD = s.cond;
    RA1D = s.ra1; RA2D = s.ra2; WA3D = s.wa3;
    RD1D = s.rd1; RD2D = s.rd2; ExtImmD = s.ext;
  endtask

  function automatic side_t observe();
    side_t s;
    s.ctl = {PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE};
    s.aluc = ALUControlE; s.flagw = FlagWE; s.cond = CondE;
    s.ra1 = RA1E; s.ra2 = RA2E; s.wa3 = WA3E;
    s.rd1 = RD1E; s.rd2 = RD2E; s.ext = ExtImmE; s.valid = ValidE;
    return s;
  endfunction

  task automatic check_side(input string name, input side_t exp);
    side_t act;
    act = observe();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: E-side got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    side_t bub, a, b, c, z, s;
    vec_t  vt[10];

    bub = '0; bub.cond = 4'hE;
    z   = '0;
    a = mk(6'b110101, 2'b10, 2'b01, 4'h3, 4'd1, 4'd2, 4'd3,
           32'h1111_2222, 32'h3333_4444, 32'h5, 1'b1);
    b = mk(6'b000010, 2'b01, 2'b00, 4'hA, 4'hF, 4'hE, 4'hD,
           32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
    c = mk(6'b100000, 2'b11, 2'b10, 4'h1, 4'd7, 4'd8, 4'd6,
           32'hCAFE_0001, 32'h0BAD_F00D, 32'h0000_1000, 1'b1);

    vt[0] = '{flush:1'b0, stall:1'b0,
              d:mk(6'b001000, 2'b00, 2'b00, 4'hE, 4'd0, 4'd0, 4'd5, 32'h0, 32'h0, 32'hFF, 1'b1),
              e:mk(6'b001000, 2'b00, 2'b00, 4'hE, 4'd0, 4'd0, 4'd5, 32'h0, 32'h0, 32'hFF, 1'b1),
              cnt:4'd0};
    vt[1] = '{flush:1'b0, stall:1'b0, d:a, e:a, cnt:4'd0};
    vt[2] = '{flush:1'b0, stall:1'b1,
              d:mk(6'h3F, 2'b11, 2'b11, 4'h0, 4'd9, 4'd9, 4'd9, 32'hDEAD, 32'hBEEF, 32'h7, 1'b1),
              e:a, cnt:4'd0};
    vt[3] = '{flush:1'b1, stall:1'b1,
              d:mk(6'b010000, 2'b00, 2'b11, 4'h0, 4'd1, 4'd1, 4'd1, 32'h9, 32'h9, 32'h9, 1'b1),
              e:bub, cnt:4'd1};
    vt[4] = '{flush:1'b0, stall:1'b0,
              d:mk(6'b010000, 2'b00, 2'b00, 4'h0, 4'd4, 4'd4, 4'd4, 32'h1, 32'h1, 32'h1, 1'b0),
              e:bub, cnt:4'd1};
    vt[5] = '{flush:1'b1, stall:1'b0, d:a, e:bub, cnt:4'd2};
    vt[6] = '{flush:1'b0, stall:1'b0, d:b, e:b, cnt:4'd2};
    vt[7] = '{flush:1'b0, stall:1'b1,
              d:mk(6'h3F, 2'b11, 2'b11, 4'h5, 4'd2, 4'd2, 4'd2, 32'h2, 32'h2, 32'h2, 1'b0),
              e:b, cnt:4'd2};
    vt[8] = '{flush:1'b0, stall:1'b0, d:c, e:c, cnt:4'd2};
    vt[9] = '{flush:1'b0, stall:1'b0,
              d:mk(6'h3F, 2'b11, 2'b11, 4'h0, 4'hF, 4'hF, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 1'b0),
              e:bub, cnt:4'd2};

    // Reset state
    reset = 1'b0;
    drive(1'b0, 1'b0, z);
    #12;
    check_side("reset_outputs", bub);
    check_val("reset_cnt", 32'(BubbleCnt), 32'd0);
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].flush, vt[i].stall, vt[i].d);
      step();
      check_side($sformatf("vec%0d_outputs", i), vt[i].e);
      check_val($sformatf("vec%0d_cnt", i), 32'(BubbleCnt), 32'(vt[i].cnt));
    end

    // Stall held three cycles
    s = z; s.valid = 1'b1; s.rd2 = 32'hAAAA_5555;
    drive(1'b0, 1'b0, s);
    step();
    check_val("stall_load_rd2", RD2E, 32'hAAAA_5555);
    for (int i = 0; i < 3; i++) begin
      s.rd2 = 32'(i + 1) * 32'h0101_0101;
      drive(1'b0, 1'b1, s);
      step();
      check_val($sformatf("stall_hold%0d_rd2", i), RD2E, 32'hAAAA_5555);
      check_val($sformatf("stall_hold%0d_valid", i), 32'(ValidE), 32'd1);
    end
    s.rd2 = 32'h1234_5678;
    drive(1'b0, 1'b0, s);
    step();
    check_val("stall_release_rd2", RD2E, 32'h1234_5678);

    // Asynchronous reset between edges
    s = z; s.valid = 1'b1; s.ctl = 6'b010000; s.cond = 4'h0; s.rd1 = 32'h1234;
    drive(1'b0, 1'b0, s);
    step();
    check_val("midrst_pre_regw", 32'(RegWE), 32'd1);
    check_val("midrst_pre_rd1", RD1E, 32'h1234);
    #2;
    reset = 1'b0;
    #1;
    check_side("midrst_outputs", bub);
    check_val("midrst_cnt", 32'(BubbleCnt), 32'd0);
    drive(1'b0, 1'b0, z);
    #3;
    reset = 1'b1;

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, a);
      step();
      check_val($sformatf("sat_edge%0d_cnt", i), 32'(BubbleCnt), (i >= 14) ? 32'd15 : 32'(i + 1));
    end
    drive(1'b0, 1'b0, a);
    step();
    check_val("sat_hold_cnt", 32'(BubbleCnt), 32'd15);
    check_side("post_sat_load", a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/de_ex_pipe_reg.md
Name: de_ex_pipe_reg

Overview:
- Decode-to-Execute pipeline register of the pipelined ARM core.
- Captures the decoded control bundle, register addresses and operand data each cycle, and presents them to the Execute stage. Execute consumes them in ALU and condition-check logic, which gates RegW/MemW/PCS/Branch/FlagW by CondEx.
- Implements hazard-unit stall and flush (bubble insertion), a per-entry valid bit, and a saturating bubble counter for performance observation.

Parameters:
- WIDTH, 32, datapath width of RD1/RD2/ExtImm.
- RAW, 4, register-address width.
- CNTW, 16, bubble-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- StallE  in  1  hold current contents.
- FlushE  in  1  load a bubble instead of decode outputs.
- ValidD  in  1  decode slot holds a real instruction.
- PCSD, RegWD, MemWD, BranchD, MemtoRegD, ALUSrcD  in  1 each  decoded control.
- ALUControlD  in  2  ALU op.
- FlagWD  in  2  flag-write enables {NZ, CV}.
- CondD  in  4  condition field.
- RA1D, RA2D, WA3D  in  RAW  source and destination register addresses.
- RD1D, RD2D, ExtImmD  in  WIDTH  operands.
- PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE  out  1 each  registered control.
- ALUControlE  out  2  registered ALU op.
- FlagWE  out  2  registered flag-write enables.
- CondE  out  4  registered condition field.
- RA1E, RA2E, WA3E  out  RAW  registered addresses.
- RD1E, RD2E, ExtImmE  out  WIDTH  registered operands.
- ValidE  out  1  Execute slot holds a real instruction.
- BubbleCnt  out  CNTW  number of bubbles inserted since reset.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-stall):
  - All outputs clear to 0, except CondE = 4'hE (AL).
  - ValidE = 0; BubbleCnt = 0.
- Latency: one cycle. Values presented in cycle n on the D-side appear on the E-side after edge n+1.
- Per-edge priority, highest first:
  - FlushE=1 (regardless of StallE): load bubble.
  - StallE=1: hold all E-side registers, including ValidE.
  - Otherwise: load D-side inputs; ValidE <= ValidD.
- Bubble contents:
  - PCSE = RegWE = MemWE = BranchE = MemtoRegE = ALUSrcE = 0.
  - FlagWE = 0; ALUControlE = 0; CondE = 4'hE.
  - RA1E = RA2E = WA3E = 0; RD1E = RD2E = ExtImmE = 0; ValidE = 0.
  - Consequence: no architectural side effect downstream, even if CondEx evaluates true.
- Invalid decode slot: ValidD=0 on a normal load also forces bubble contents, but this is not counted as an inserted bubble.
- BubbleCnt:
  - Increments by 1 on each edge where FlushE=1.
  - Saturates at 2^CNTW-1 with no wrap.
  - Unaffected by StallE.
- No combinational path from any input to any output; all outputs are registered.
- Simultaneous FlushE and StallE: flush wins; counter increments.
- Stall held N cycles: outputs are stable for N cycles and the next load occurs on the first edge with StallE=0.

Decomposition:
- Package pipe_pkg:
  - struct ctrl_e_t bundling PCS, RegW, MemW, Branch, MemtoReg, ALUSrc, ALUControl[1:0], FlagW[1:0], Cond[3:0], Valid.
  - Constant COND_AL = 4'hE.
  - Constant CTRL_BUBBLE, the bubble value of ctrl_e_t.
- One natural sub-module: flopenrc_n, a parameterised flop with enable and synchronous clear plus asynchronous active-low reset. It is instantiated for the control, address and data fields; reset value for Cond is supplied by parameter.
- The saturating counter stays inline.

Test Plan:
- Reset mid-operation:
  - Load RegWD=1, CondD=4'h0, RD1D=32'h1234, then pull reset low between edges.
  - Required: outputs clear immediately without waiting for an edge; CondE=4'hE, ValidE=0, BubbleCnt=0.
- Normal flow:
  - Drive ValidD=1, MemWD=1, WA3D=4'd5, ExtImmD=32'h0000_00FF for one cycle.
  - Required: after the next edge, MemWE=1, WA3E=5, ExtImmE=32'hFF, ValidE=1; the following edge loads the next D-side value.
- Stall:
  - Load RD2D=32'hAAAA_5555, then assert StallE for 3 cycles while changing D-side inputs.
  - Required: RD2E stays 32'hAAAA_5555 for all 3 cycles and updates on the first unstalled edge.
- Flush vs stall:
  - Assert FlushE=1 and StallE=1 together with RegWD=1, FlagWD=2'b11.
  - Required: RegWE=0, FlagWE=0, CondE=4'hE, ValidE=0; BubbleCnt goes from 0 to 1.
- Counter saturation:
  - With CNTW=4, assert FlushE for 20 consecutive edges.
  - Required: BubbleCnt reaches 15 and holds.
- Invalid slot:
  - Drive ValidD=0 with RegWD=1 on a normal load.
  - Required: RegWE=0 and ValidE=0; BubbleCnt unchanged.
